// File: rtl/cpu_input_feeder.sv
// cpu_input_feeder: host-side driver for the CPU keyboard-style input port.
// Bytes pushed by the host are buffered in a small circular FIFO. While the
// control unit waits in its input state (in_req), the FIFO head is presented
// on Nin and an enter strobe of at least HOLD_CYCLES cycles is generated.
// Optional build macro HALT_FLUSH_EN: halt flushes the FIFO and aborts the
// handshake; without it halt is ignored.

module cpu_input_feeder #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic                   in_req,
   input  logic                   halt,
   output logic [7:0]             Nin,
   output logic                   enter,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [HW-1:0] hold, hold_nxt;
   logic          enter_nxt;
   logic [7:0]    nin_nxt;
   logic          pop, push, flush;

`ifdef HALT_FLUSH_EN
   assign flush = halt;
`else
   logic unused_halt;
   assign unused_halt = halt;
   assign flush       = 1'b0;
`endif

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   assign busy  = (state != IDLE);
   // full is the pre-edge value, so a push into a full FIFO is dropped even
   // when the handshake pops in the same cycle
   assign push  = wr_en && !full && !flush;

   // FIFO storage write port
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en && full && !flush) overflow <= 1'b1;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // handshake state register with registered Nin/enter outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         enter <= 1'b0;
         hold  <= '0;
         Nin   <= '0;
      end else begin
         state <= state_nxt;
         enter <= enter_nxt;
         hold  <= hold_nxt;
         Nin   <= nin_nxt;
      end
   end

   // handshake next-state, hold countdown and pop decision
   always_comb begin
      state_nxt = state;
      enter_nxt = enter;
      hold_nxt  = hold;
      nin_nxt   = Nin;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (in_req && !empty) begin
               nin_nxt   = mem[rd_ptr];
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = STROBE;
            enter_nxt = 1'b1;
            hold_nxt  = HOLD_LOAD;
         end
         STROBE: begin
            if (hold != '0) begin
               hold_nxt = hold - 1'b1;
            end else if (!in_req) begin
               pop       = 1'b1;
               enter_nxt = 1'b0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         enter_nxt = 1'b0;
         pop       = 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_input_feeder.sv
// tb_cpu_input_feeder: randomized bench for cpu_input_feeder. A timeline
// reference model (byte queue plus edge-indexed handshake rules) runs in the
// monitor; delivered bytes are queued at acceptance and popped when enter
// rises. Asynchronous reset is pulsed mid-strobe between phases.

module tb_cpu_input_feeder;

   localparam int DEPTH = 4;
   localparam int HOLD  = 4;

   logic       clock = 1'b0;
   logic       reset, wr_en, in_req, halt;
   logic [7:0] wr_data;
   logic [7:0] Nin;
   logic       enter, full, empty, overflow, busy;
   logic [2:0] count;

   cpu_input_feeder #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .in_req(in_req), .halt(halt), .Nin(Nin), .enter(enter),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .busy(busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // reference model state
   byte unsigned q[$];      // bytes held in the FIFO
   byte unsigned sb[$];     // bytes accepted for delivery, awaiting enter rise
   bit           m_enter = 0;
   bit           m_ovf   = 0;
   logic [7:0]   m_nin   = '0;
   int           held    = 0;
   int           rise_at = -1;
   int           ok_edge = 0;
   int           edge_n  = 0;
   logic         p_wr = 0, p_req = 0, p_halt = 0;
   logic [7:0]   p_data = '0;
   bit           rst_pulse = 0;
   bit           mon_on    = 0;
   bit           prev_enter = 0;

   // monitor: advance the model over the edge just passed, then compare
   always @(negedge clock) begin
      if (mon_on) begin
         bit pre_full;
         edge_n++;
         if (rst_pulse) begin
            rst_pulse  = 0;
            q.delete();
            sb.delete();
            m_enter    = 0;
            m_ovf      = 0;
            m_nin      = '0;
            held       = 0;
            rise_at    = -1;
            ok_edge    = edge_n;
            prev_enter = 0;
         end
         pre_full = (q.size() >= DEPTH);
`ifdef HALT_FLUSH_EN
         if (p_halt) begin
            q.delete();
            sb.delete();
            m_enter = 0;
            rise_at = -1;
            ok_edge = edge_n + 1;
         end else begin
`else
         begin
`endif
            if (m_enter) begin
               held++;
               if (held >= HOLD && !p_req) begin
                  m_enter = 0;
                  void'(q.pop_front());
                  ok_edge = edge_n + 2;
               end
            end else if (rise_at == edge_n) begin
               m_enter = 1;
               held    = 0;
            end else if (rise_at < edge_n && edge_n >= ok_edge && p_req && q.size() > 0) begin
               rise_at = edge_n + 1;
               m_nin   = q[0];
               sb.push_back(q[0]);
            end
            if (p_wr) begin
               if (!pre_full) q.push_back(p_data);
               else m_ovf = 1;
            end
         end

         check("enter", enter, m_enter);
         check("Nin", Nin, m_nin);
         check("count", count, q.size());
         check("full", full, q.size() == DEPTH);
         check("empty", empty, q.size() == 0);
         check("overflow", overflow, m_ovf);
         check("busy", busy, (rise_at > edge_n) || m_enter || (edge_n < ok_edge - 1));

         if (enter && !prev_enter) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL delivered actual=%0h required=none", Nin);
            end else begin
               check("delivered", Nin, sb.pop_front());
            end
         end
         prev_enter = enter;

         p_wr   = wr_en;
         p_data = wr_data;
         p_req  = in_req;
         p_halt = halt;
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_enter"}, enter, 0);
      check({tag, "_count"}, count, 0);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_full"}, full, 0);
      check({tag, "_Nin"}, Nin, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   int wr_pct[4] = '{70, 30, 10, 50};

   // stimulus: random pushes, CPU-like in_req runs, occasional halt
   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      in_req  = 1'b0;
      halt    = 1'b0;
      #3;
      check_reset_state("rst0");
      rst_pulse = 1;
      #5 reset = 1'b0;
      mon_on = 1;

      for (int ph = 0; ph < 4; ph++) begin
         int run_left = 0;
         int cyc      = 0;
         bit hit      = 0;
         bit timeout  = 0;
         while (!hit) begin
            @(posedge clock);
            #1;
            if (cyc >= 500 && enter) begin
               hit = 1;
            end else if (cyc >= 900) begin
               hit     = 1;
               timeout = 1;
               checks++;
               errors++;
               $display("FAIL strobe_wait actual=%0d required=enter", enter);
            end else begin
               wr_en   = ($urandom_range(0, 99) < wr_pct[ph]);
               wr_data = 8'($urandom);
               if (run_left == 0) begin
                  in_req   = ~in_req;
                  run_left = in_req ? $urandom_range(1, 16) : $urandom_range(1, 8);
               end
               run_left--;
               halt = ($urandom_range(0, 9) == 0);
            end
            cyc++;
         end
         if (!timeout) begin
            @(negedge clock);
            #2 reset = 1'b1;
            #1 check_reset_state("rst_mid");
            rst_pulse = 1;
            #1 reset = 1'b0;
         end
      end

      @(posedge clock);
      #1;
      wr_en  = 1'b0;
      in_req = 1'b0;
      halt   = 1'b0;
      repeat (20) @(posedge clock);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
